// File: rtl/pipe_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_run_ctrl
//  Purpose  : Run / halt / single-step sequencer for the 5-stage RVX10-P
//             pipeline. Merges raw hazard-unit stall/flush requests with its
//             own control so the pipeline can be frozen at fetch, drained of
//             in-flight instructions, stepped one instruction at a time, and
//             resumed. Also keeps a retired-instruction counter.
//  Ports    :
//    clk, reset (async, active-low)
//    halt_req / resume_req / step_req  level-sampled control requests
//    cnt_clr                            synchronous clear of retire_count
//    StallF_hz..FlushE_hz, PCSrcE       raw hazard requests / redirect
//    validD..validW                     per-stage valid bits
//    StallF..FlushE                     merged controls to the datapath
//    halted, step_done, retire_count, state   status
//  Revision : 1.0  initial release
// ============================================================================
module pipe_run_ctrl #(
    parameter int   CNT_W        = 32,
    parameter logic RESET_HALTED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    input  logic             cnt_clr,
    input  logic             StallF_hz,
    input  logic             StallD_hz,
    input  logic             FlushD_hz,
    input  logic             FlushE_hz,
    input  logic             PCSrcE,
    input  logic             validD,
    input  logic             validE,
    input  logic             validM,
    input  logic             validW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             halted,
    output logic             step_done,
    output logic [CNT_W-1:0] retire_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        c_RUN    = 2'd0,
        c_DRAIN  = 2'd1,
        c_HALTED = 2'd2,
        c_STEP   = 2'd3
    } state_t;

    localparam state_t          c_RESET_STATE = RESET_HALTED ? c_HALTED : c_RUN;
    localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_stateNext;
    // Marks that the current DRAIN was started by a single step, so leaving
    // it must pulse step_done.
    logic             r_stepFlag;
    logic             w_stepFlagNext;
    logic             r_stepDone;
    logic             w_stepDoneNext;
    logic [CNT_W-1:0] r_retireCount;
    logic             w_pipeEmpty;

    assign w_pipeEmpty = ~(validD | validE | validM | validW);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_RESET_STATE;
            r_stepFlag <= 1'b0;
            r_stepDone <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_stepFlag <= w_stepFlagNext;
            r_stepDone <= w_stepDoneNext;
        end
    end

    // ------------------------------------------------------------------
    // Next state and merged pipeline controls
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext    = r_state;
        w_stepFlagNext = r_stepFlag;
        w_stepDoneNext = 1'b0;
        StallF         = StallF_hz;
        StallD         = StallD_hz;
        FlushD         = FlushD_hz;
        FlushE         = FlushE_hz;

        case (r_state)
            c_RUN: begin
                if (halt_req) begin
                    w_stateNext    = c_DRAIN;
                    w_stepFlagNext = 1'b0;
                end
            end

            c_DRAIN: begin
                // Fetch frozen, but a taken redirect still lands in PC so the
                // resume point is the branch target. Decode passes its
                // instruction on and refills with a bubble unless a load-use
                // stall is holding it.
                StallF = StallF_hz | ~PCSrcE;
                FlushD = FlushD_hz | ~StallD_hz;
                if (w_pipeEmpty) begin
                    w_stateNext    = c_HALTED;
                    w_stepFlagNext = 1'b0;
                    w_stepDoneNext = r_stepFlag;
                end
            end

            c_HALTED: begin
                StallF = ~PCSrcE;
                StallD = 1'b0;
                FlushD = 1'b1;
                if (resume_req) begin
                    w_stateNext = c_RUN;
                end else if (step_req) begin
                    w_stateNext = c_STEP;
                end
            end

            c_STEP: begin
                // One open fetch cycle: exactly one instruction enters Decode.
                StallF         = 1'b0;
                StallD         = 1'b0;
                FlushD         = 1'b0;
                w_stateNext    = c_DRAIN;
                w_stepFlagNext = 1'b1;
            end

            default: begin
                w_stateNext = c_RESET_STATE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Retired-instruction counter (counts in every state, clear wins)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retireCount <= '0;
        end else if (cnt_clr) begin
            r_retireCount <= '0;
        end else if (validW) begin
            r_retireCount <= r_retireCount + c_CNT_ONE;
        end
    end

    assign halted       = (r_state == c_HALTED);
    assign step_done    = r_stepDone;
    assign retire_count = r_retireCount;
    assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_run_ctrl
//  Purpose  : Self-checking bench for pipe_run_ctrl. Table-driven checks of
//             the output merge per state, plus hand sequences against a small
//             behavioural pipeline (PC, stage valid bits) driven by the DUT.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // direct stimulus
    logic reset = 1'b0;
    logic halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0, cnt_clr = 1'b0;
    logic tStallF = 1'b0, tStallD = 1'b0, tFlushD = 1'b0, tFlushE = 1'b0, tPCSrcE = 1'b0;
    logic tValidD = 1'b0, tValidE = 1'b0, tValidM = 1'b0, tValidW = 1'b0;
    logic useModel = 1'b0;

    // behavioural pipeline
    logic        mD = 1'b0, mE = 1'b0, mM = 1'b0, mW = 1'b0;
    logic [31:0] pcF = 32'h0, pcD = 32'h0, pcE = 32'h0;
    logic [31:0] jalPc = 32'hFFFF_FFFF;
    logic        loadPc = 1'b0;
    logic [31:0] loadPcVal = 32'h0;

    logic pcSrcE, flushDHz, flushEHz, vD, vE, vM, vW;
    assign pcSrcE   = useModel ? (mE && (pcE == jalPc)) : tPCSrcE;
    assign flushDHz = tFlushD | (useModel & pcSrcE);
    assign flushEHz = tFlushE | (useModel & pcSrcE);
    assign vD = useModel ? mD : tValidD;
    assign vE = useModel ? mE : tValidE;
    assign vM = useModel ? mM : tValidM;
    assign vW = useModel ? mW : tValidW;

    logic        StallF, StallD, FlushD, FlushE, halted, step_done;
    logic [31:0] retire_count;
    logic [1:0]  state;

    pipe_run_ctrl #(.CNT_W(32), .RESET_HALTED(1'b0)) dut (
        .clk(clk), .reset(reset),
        .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req), .cnt_clr(cnt_clr),
        .StallF_hz(tStallF), .StallD_hz(tStallD), .FlushD_hz(flushDHz), .FlushE_hz(flushEHz),
        .PCSrcE(pcSrcE),
        .validD(vD), .validE(vE), .validM(vM), .validW(vW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .halted(halted), .step_done(step_done), .retire_count(retire_count), .state(state)
    );

    // narrow-counter instance, starts halted
    logic       u2ValidW = 1'b0, u2Clr = 1'b0;
    logic       u2StallF, u2StallD, u2FlushD, u2FlushE, u2Halted, u2StepDone;
    logic [3:0] u2Count;
    logic [1:0] u2State;

    pipe_run_ctrl #(.CNT_W(4), .RESET_HALTED(1'b1)) dut2 (
        .clk(clk), .reset(reset),
        .halt_req(1'b0), .resume_req(1'b0), .step_req(1'b0), .cnt_clr(u2Clr),
        .StallF_hz(1'b0), .StallD_hz(1'b0), .FlushD_hz(1'b0), .FlushE_hz(1'b0),
        .PCSrcE(1'b0),
        .validD(1'b0), .validE(1'b0), .validM(1'b0), .validW(u2ValidW),
        .StallF(u2StallF), .StallD(u2StallD), .FlushD(u2FlushD), .FlushE(u2FlushE),
        .halted(u2Halted), .step_done(u2StepDone), .retire_count(u2Count), .state(u2State)
    );

    // pipeline registers: flush beats enable (clear-priority flops)
    always @(posedge clk) begin
        if (loadPc)       pcF <= loadPcVal;
        else if (!StallF) pcF <= pcSrcE ? 32'h200 : pcF + 32'd4;
        if (FlushD)       mD <= 1'b0;
        else if (!StallD) begin mD <= 1'b1; pcD <= pcF; end
        if (FlushE)       mE <= 1'b0;
        else              begin mE <= mD; pcE <= pcD; end
        mM <= mE;
        mW <= mM;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] st;
        logic       sf, sd, fd, fe, pc;
        logic [3:0] exp;   // {StallF, StallD, FlushD, FlushE}
    } vec_t;
    vec_t vecs[10];

    task automatic applyVec(input int i);
        tStallF = vecs[i].sf; tStallD = vecs[i].sd; tFlushD = vecs[i].fd;
        tFlushE = vecs[i].fe; tPCSrcE = vecs[i].pc;
        #1;
        chk($sformatf("merge[%0d]", i), 32'({StallF, StallD, FlushD, FlushE}), 32'(vecs[i].exp));
    endtask

    task automatic clearHz();
        tStallF = 1'b0; tStallD = 1'b0; tFlushD = 1'b0; tFlushE = 1'b0; tPCSrcE = 1'b0;
    endtask

    int          pulses;
    logic [31:0] cnt0, pc0;

    initial begin
        vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[1] = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101};
        vecs[2] = '{2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010};
        vecs[3] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010};
        vecs[4] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010};
        vecs[5] = '{2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101};
        vecs[6] = '{2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010};
        vecs[7] = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010};
        vecs[8] = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0011};
        vecs[9] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010};

        // ---------------- reset ----------------
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("rst state", 32'(state), 0);
        chk("rst ctrl", 32'({StallF, StallD, FlushD, FlushE}), 0);
        chk("rst count", retire_count, 0);
        chk("rst step_done", 32'(step_done), 0);
        chk("u2 rst state", 32'(u2State), 2);
        chk("u2 rst halted", 32'(u2Halted), 1);
        chk("u2 rst count", 32'(u2Count), 0);
        chk("u2 rst ctrl", 32'({u2StallF, u2StallD, u2FlushD, u2FlushE, u2StepDone}), 32'b10100);

        // ---------------- merge table per state ----------------
        for (int i = 0; i < 10; i++) if (vecs[i].st == state) applyVec(i);
        clearHz();
        tValidD = 1'b1; halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("enter drain", 32'(state), 1);
        for (int i = 0; i < 10; i++) if (vecs[i].st == state) applyVec(i);
        clearHz();
        tValidD = 1'b0;
        tick();
        chk("drain->halted", 32'(state), 2);
        for (int i = 0; i < 10; i++) if (vecs[i].st == state) applyVec(i);
        // STEP state outputs
        tStallF = 1'b1; tStallD = 1'b1; tFlushD = 1'b1; tFlushE = 1'b1;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step state", 32'(state), 3);
        chk("step ctrl", 32'({StallF, StallD, FlushD, FlushE}), 32'b0001);
        clearHz();
        tick();
        chk("step drain state", 32'(state), 1);
        tick();
        chk("step -> halted", 32'(state), 2);
        chk("step_done pulse", 32'(step_done), 1);
        tick();
        chk("step_done clears", 32'(step_done), 0);
        // drain with empty pipe leaves on the edge right after entry
        resume_req = 1'b1; tick(); resume_req = 1'b0;
        chk("resume", 32'(state), 0);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("empty drain entry", 32'(state), 1);
        tick();
        chk("empty drain exit", 32'(state), 2);
        chk("no step_done on halt", 32'(step_done), 0);
        resume_req = 1'b1; tick(); resume_req = 1'b0;

        // ---------------- full-pipeline drain ----------------
        useModel = 1'b1;
        repeat (6) tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;   // edge 0
        chk("drain st", 32'(state), 1);
        chk("drain FlushD", 32'(FlushD), 1);
        chk("drain StallF", 32'(StallF), 1);
        cnt0 = retire_count; pc0 = pcF;
        repeat (4) tick();                         // edges 1..4
        chk("not halted at edge4", 32'(halted), 0);
        tick();                                    // edge 5
        chk("halted at edge5", 32'(halted), 1);
        chk("PC frozen", pcF, pc0);
        chk("retired 4", retire_count, cnt0 + 32'd4);

        // ---------------- drain with a load-use stall ----------------
        resume_req = 1'b1; tick(); resume_req = 1'b0;
        repeat (6) tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;   // edge 0
        cnt0 = retire_count;
        tStallF = 1'b1; tStallD = 1'b1; tFlushE = 1'b1;
        #1;
        chk("loaduse FlushD", 32'(FlushD), 0);
        chk("loaduse StallD", 32'(StallD), 1);
        tick();                                    // edge 1
        clearHz();
        repeat (4) tick();                         // edges 2..5
        chk("loaduse not halted e5", 32'(halted), 0);
        tick();                                    // edge 6
        chk("loaduse halted e6", 32'(halted), 1);
        chk("loaduse retired 4", retire_count, cnt0 + 32'd4);

        // ---------------- single step, plain and taken jal ----------------
        for (int k = 0; k < 2; k++) begin
            jalPc = (k == 1) ? 32'h100 : 32'hFFFF_FFFF;
            loadPcVal = 32'h100; loadPc = 1'b1; tick(); loadPc = 1'b0;
            cnt0 = retire_count;
            step_req = 1'b1; tick(); step_req = 1'b0;
            chk("step entered", 32'(state), 3);
            pulses = 0;
            for (int j = 0; j < 10; j++) begin
                tick();
                pulses += int'(step_done);
            end
            chk($sformatf("step%0d pulses", k), 32'(pulses), 1);
            chk($sformatf("step%0d retired", k), retire_count, cnt0 + 32'd1);
            chk($sformatf("step%0d PC", k), pcF, (k == 1) ? 32'h200 : 32'h104);
            chk($sformatf("step%0d halted", k), 32'(halted), 1);
        end
        jalPc = 32'hFFFF_FFFF;

        // ---------------- resume beats step ----------------
        resume_req = 1'b1; step_req = 1'b1; tick();
        resume_req = 1'b0; step_req = 1'b0;
        chk("resume priority", 32'(state), 0);
        tick();
        chk("resume no step_done", 32'(step_done), 0);

        // ---------------- reset mid-drain ----------------
        repeat (6) tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("middrain st", 32'(state), 1);
        reset = 1'b0; #1;
        chk("async rst drain", 32'(state), 0);
        chk("async rst count", retire_count, 0);
        reset = 1'b1;

        // ---------------- reset mid-step ----------------
        repeat (6) tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        repeat (10) tick();
        chk("midstep pre halted", 32'(halted), 1);
        step_req = 1'b1; tick(); step_req = 1'b0;
        tick();
        chk("midstep drain", 32'(state), 1);
        reset = 1'b0; #1;
        chk("async rst step", 32'(state), 0);
        reset = 1'b1;
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            pulses += int'(step_done);
        end
        chk("no partial step_done", 32'(pulses), 0);

        // ---------------- counter clear ----------------
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("clr beats inc", retire_count, 0);
        tick();
        chk("count after clr", retire_count, 1);

        // ---------------- narrow counter wrap ----------------
        u2ValidW = 1'b1;
        repeat (15) tick();
        chk("u2 max", 32'(u2Count), 15);
        tick();
        chk("u2 wrap", 32'(u2Count), 0);
        repeat (2) tick();
        u2Clr = 1'b1; tick();
        chk("u2 clr+valid", 32'(u2Count), 0);
        u2Clr = 1'b0; u2ValidW = 1'b0; tick();
        chk("u2 idle", 32'(u2Count), 0);
        chk("u2 still halted", 32'(u2State), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
- Run/halt/single-step sequencer for the 5-stage RVX10-P pipeline.
- Sits between the hazard unit and the datapath, merging hazard stall/flush requests with its own control.
- Halting freezes fetch, injects bubbles into Decode and drains in-flight instructions, tracked with the per-stage valid bits, until the pipeline is empty.
- Also supports single-instruction stepping and keeps a retired-instruction counter.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- RESET_HALTED, 0: 1 = the state after reset is HALTED; 0 = RUN.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- halt_req  in  1  request halt; sampled in RUN only.
- resume_req  in  1  request resume; sampled in HALTED only.
- step_req  in  1  request single step; sampled in HALTED only.
- cnt_clr  in  1  synchronous clear of retire_count.
- StallF_hz, StallD_hz, FlushD_hz, FlushE_hz  in  1 each  raw requests from the hazard unit.
- PCSrcE  in  1  taken branch/jump redirect in Execute.
- validD, validE, validM, validW  in  1 each  stage valid bits from the datapath.
- StallF, StallD, FlushD, FlushE  out  1 each  merged controls driven to the datapath.
- halted  out  1  high while in HALTED.
- step_done  out  1  one-cycle pulse on a STEP_DRAIN to HALTED transition.
- retire_count  out  CNT_W  number of cycles with validW=1.
- state  out  2  encoding: RUN=0, DRAIN=1, HALTED=2, STEP=3.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = HALTED if RESET_HALTED=1, else RUN.
  - retire_count = 0; step_done = 0.
- FSM, registered:
  - RUN: if halt_req, go to DRAIN.
  - DRAIN: if validD, validE, validM and validW are all 0, go to HALTED. This is evaluated on every edge, including the edge after entry.
  - HALTED: if resume_req, go to RUN; else if step_req, go to STEP. resume_req has priority.
  - STEP: unconditionally go to STEP_DRAIN for one cycle. STEP_DRAIN is encoded as DRAIN plus an internal step flag. It leaves to HALTED under the same condition as DRAIN and pulses step_done on that edge.
  - Requests are level-sampled. Requests are ignored in states where they are not listed above.
- Output merge (combinational):
  - RUN: StallF=StallF_hz, StallD=StallD_hz, FlushD=FlushD_hz, FlushE=FlushE_hz (pure pass-through).
  - DRAIN / STEP_DRAIN:
    - StallF = StallF_hz | ~PCSrcE. PC is frozen, except that a taken redirect still updates PC, so the resume point is correct.
    - StallD = StallD_hz.
    - FlushD = FlushD_hz | ~StallD_hz. The Decode instruction advances to Execute and Decode refills with a bubble; a load-use stall holds Decode instead.
    - FlushE = FlushE_hz.
  - HALTED: StallF = ~PCSrcE, StallD=0, FlushD=1, FlushE=FlushE_hz.
  - STEP: StallF=0, StallD=0, FlushD=0, FlushE=FlushE_hz. Exactly one instruction is fetched into Decode and PC advances by 4.
- Counter:
  - retire_count increments by 1 on each edge where validW=1 and wraps modulo 2^CNT_W.
  - If cnt_clr=1, the counter loads 0; clear beats increment.
  - The counter counts in all states.
- Outputs: halted = (state==HALTED); step_done is registered.
- Drain latency with the pipeline full and no stalls:
  - halt_req is sampled at edge 0 and the state is DRAIN after edge 0.
  - Bubbles fill D, E, M, W over edges 1–4.
  - HALTED is entered at edge 5.
  - Each load-use stall cycle during the drain adds one cycle.
- Reset mid-drain or mid-step: the block returns immediately to the reset state, with no partial step_done.

Test Plan:
- Reset with RESET_HALTED=0 and all hz inputs 0 → state=0, StallF=StallD=FlushD=FlushE=0, retire_count=0.
- Pipeline full (all valid=1), halt_req pulsed at edge 0 → halted=1 from edge 5. FlushD=1 from the cycle after edge 0. PCF is unchanged from edge 0 onwards. retire_count has increased by 4.
- Drain with a load-use (StallD_hz=1 for 1 cycle while D is valid) → FlushD=0 in that cycle. HALTED is reached at edge 6. The stalled instruction still retires.
- Halted at PC=0x100, step_req → exactly one validW pulse; step_done pulses once; PCF=0x104; halted=1 again. If the stepped instruction is a taken jal to 0x200, PCF=0x200.
- Halted with resume_req=1 and step_req=1 together → state=RUN, with no step_done.
- Counter at 2^CNT_W−1 with validW=1 → wraps to 0. cnt_clr=1 together with validW=1 → 0.
